// File: rtl/mem_wb.sv
// MEM/WB pipeline register: captures MEM-stage results for the write-back stage,
// with synchronous reset, flush (bubble) and stall (hold), plus the write-back data mux.
module mem_wb #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              MEM_regwrite,
    input  logic              MEM_memtoreg,
    input  logic [DATA_W-1:0] MEM_rdata,
    input  logic [DATA_W-1:0] MEM_out,
    input  logic [REG_AW-1:0] MEM_rd,
    output logic              WB_regwrite,
    output logic              WB_memtoreg,
    output logic [DATA_W-1:0] WB_rdata,
    output logic [DATA_W-1:0] WB_out,
    output logic [REG_AW-1:0] WB_rd,
    output logic [DATA_W-1:0] WB_wdata
);

    // A bubble is all zeros, so regwrite=0 guarantees no register-file write for that slot.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            WB_regwrite <= 1'b0;
            WB_memtoreg <= 1'b0;
            WB_rdata    <= '0;
            WB_out      <= '0;
            WB_rd       <= '0;
        end else if (!stall) begin
            WB_regwrite <= MEM_regwrite;
            WB_memtoreg <= MEM_memtoreg;
            WB_rdata    <= MEM_rdata;
            WB_out      <= MEM_out;
            WB_rd       <= MEM_rd;
        end
    end

    assign WB_wdata = WB_memtoreg ? WB_rdata : WB_out;

endmodule

// File: tb/tb_mem_wb.sv
// Scoreboard bench for mem_wb: stimulus pushes the expected WB tuple, a monitor
// pops and compares it just after each rising edge.
module tb_mem_wb;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] rdata;
        logic [31:0] out;
        logic [2:0]  rd;
    } wb_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        mem_regwrite;
    logic        mem_memtoreg;
    logic [31:0] mem_rdata;
    logic [31:0] mem_out;
    logic [2:0]  mem_rd;
    logic        wb_regwrite;
    logic        wb_memtoreg;
    logic [31:0] wb_rdata;
    logic [31:0] wb_out;
    logic [2:0]  wb_rd;
    logic [31:0] wb_wdata;

    int  checks   = 0;
    int  failures = 0;
    wb_t model_state;
    bit  model_known = 0;
    wb_t expected_q[$];

    mem_wb #(.DATA_W(32), .REG_AW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .MEM_regwrite (mem_regwrite),
        .MEM_memtoreg (mem_memtoreg),
        .MEM_rdata    (mem_rdata),
        .MEM_out      (mem_out),
        .MEM_rd       (mem_rd),
        .WB_regwrite  (wb_regwrite),
        .WB_memtoreg  (wb_memtoreg),
        .WB_rdata     (wb_rdata),
        .WB_out       (wb_out),
        .WB_rd        (wb_rd),
        .WB_wdata     (wb_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, actual, required);
        end
    endtask

    task automatic check_output(input string tag, input wb_t exp);
        logic [31:0] exp_wdata;
        exp_wdata = exp.memtoreg ? exp.rdata : exp.out;
        compare({tag, ".regwrite"}, {31'd0, wb_regwrite}, {31'd0, exp.regwrite});
        compare({tag, ".memtoreg"}, {31'd0, wb_memtoreg}, {31'd0, exp.memtoreg});
        compare({tag, ".rdata"},    wb_rdata,             exp.rdata);
        compare({tag, ".out"},      wb_out,               exp.out);
        compare({tag, ".rd"},       {29'd0, wb_rd},       {29'd0, exp.rd});
        compare({tag, ".wdata"},    wb_wdata,             exp_wdata);
    endtask

    // Drives one cycle of inputs on the falling edge; outputs must not move before the next rising edge.
    task automatic apply_stimulus(input bit r, input bit f, input bit s,
                                  input bit rw, input bit mtr, input logic [31:0] rdata,
                                  input logic [31:0] out, input logic [2:0] rd);
        wb_t loaded;
        @(negedge clk);
        rst = r; flush = f; stall = s;
        mem_regwrite = rw; mem_memtoreg = mtr;
        mem_rdata = rdata; mem_out = out; mem_rd = rd;
        #1;
        if (model_known) check_output("hold_between_edges", model_state);
        loaded = '{regwrite: rw, memtoreg: mtr, rdata: rdata, out: out, rd: rd};
        if (r || f)  model_state = '0;
        else if (!s) model_state = loaded;
        model_known = 1;
        expected_q.push_back(model_state);
    endtask

    task automatic apply_random(input bit r, input bit f, input bit s);
        apply_stimulus(r, f, s, 1'($urandom), 1'($urandom), $urandom, $urandom, 3'($urandom));
    endtask

    initial begin : monitor
        wb_t exp;
        forever begin
            @(posedge clk);
            #1;
            if (expected_q.size() > 0) begin
                exp = expected_q.pop_front();
                check_output("after_edge", exp);
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        mem_regwrite = 1'b1; mem_memtoreg = 1'b1;
        mem_rdata = 32'hdead_beef; mem_out = 32'hcafe_f00d; mem_rd = 3'd5;

        apply_random(1, 0, 0);
        apply_random(1, 1, 1);

        apply_stimulus(0, 0, 0, 0, 0, 32'd12, 32'd23, 3'd1);
        apply_stimulus(0, 0, 0, 1, 1, 32'd22, 32'd31, 3'd0);

        for (int i = 0; i < 8; i++) apply_random(0, 0, 0);

        apply_stimulus(0, 0, 0, 1, 0, 32'd5, 32'd7, 3'd3);
        for (int i = 0; i < 3; i++) apply_random(0, 0, 1);
        apply_random(0, 0, 0);

        apply_stimulus(0, 0, 0, 1, 1, 32'haaaa_5555, 32'h1234_5678, 3'd7);
        apply_random(0, 1, 1);
        apply_random(0, 0, 0);
        apply_random(0, 1, 0);
        apply_random(0, 0, 0);
        apply_random(1, 0, 1);
        apply_random(0, 0, 0);

        for (int i = 0; i < 200; i++)
            apply_random($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);

        @(negedge clk);
        @(negedge clk);
        compare("scoreboard_drained", 32'(expected_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
